// File: rtl/cordic_arbiter.sv
// Round-robin arbiter sharing one fixed-latency cordic core between two job requesters.
// Define CORDIC_ARB_FIXED_PRIO_EN to make requester 0 always win simultaneous requests.
module cordic_arbiter #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_mode,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  input  logic [WIDTH-1:0] req0_z,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_mode,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  input  logic [WIDTH-1:0] req1_z,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_res1,
  output logic [WIDTH-1:0] resp_res2,
  output logic             cor_mode,
  output logic [WIDTH-1:0] cor_x,
  output logic [WIDTH-1:0] cor_y,
  output logic [WIDTH-1:0] cor_z,
  input  logic [WIDTH-1:0] cor_res1,
  input  logic [WIDTH-1:0] cor_res2,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  state_t           state, state_next;
  logic             rr_ptr, rr_ptr_next;
  logic             owner, owner_next;
  logic [7:0]       count, count_next;
  logic             cor_mode_next;
  logic [WIDTH-1:0] cor_x_next, cor_y_next, cor_z_next;
  logic [WIDTH-1:0] res1_next, res2_next;
  logic             resp0_valid_next, resp1_valid_next;
  logic             grant_valid, grant_sel;

  always_comb begin
    grant_valid = req0_valid | req1_valid;
`ifdef CORDIC_ARB_FIXED_PRIO_EN
    grant_sel = ~req0_valid;
`else
    if (req0_valid && req1_valid) grant_sel = rr_ptr;
    else                          grant_sel = req1_valid;
`endif
  end

  assign req0_ready = (state == IDLE) & grant_valid & ~grant_sel;
  assign req1_ready = (state == IDLE) & grant_valid &  grant_sel;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= 1'b0;
      owner       <= 1'b0;
      count       <= '0;
      cor_mode    <= 1'b0;
      cor_x       <= '0;
      cor_y       <= '0;
      cor_z       <= '0;
      resp_res1   <= '0;
      resp_res2   <= '0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
    end else begin
      state       <= state_next;
      rr_ptr      <= rr_ptr_next;
      owner       <= owner_next;
      count       <= count_next;
      cor_mode    <= cor_mode_next;
      cor_x       <= cor_x_next;
      cor_y       <= cor_y_next;
      cor_z       <= cor_z_next;
      resp_res1   <= res1_next;
      resp_res2   <= res2_next;
      resp0_valid <= resp0_valid_next;
      resp1_valid <= resp1_valid_next;
    end
  end

  always_comb begin
    state_next       = state;
    rr_ptr_next      = rr_ptr;
    owner_next       = owner;
    count_next       = count;
    cor_mode_next    = cor_mode;
    cor_x_next       = cor_x;
    cor_y_next       = cor_y;
    cor_z_next       = cor_z;
    res1_next        = resp_res1;
    res2_next        = resp_res2;
    resp0_valid_next = resp0_valid;
    resp1_valid_next = resp1_valid;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          state_next = WAIT;
          owner_next = grant_sel;
          count_next = CNT_INIT;
          if (grant_sel) begin
            cor_mode_next = req1_mode;
            cor_x_next    = req1_x;
            cor_y_next    = req1_y;
            cor_z_next    = req1_z;
          end else begin
            cor_mode_next = req0_mode;
            cor_x_next    = req0_x;
            cor_y_next    = req0_y;
            cor_z_next    = req0_z;
          end
        end
      end
      WAIT: begin
        // Operands stay frozen; results are taken exactly LATENCY edges after launch.
        if (count != 8'd0) begin
          count_next = count - 8'd1;
        end else begin
          res1_next  = cor_res1;
          res2_next  = cor_res2;
          state_next = RESP;
          if (owner) resp1_valid_next = 1'b1;
          else       resp0_valid_next = 1'b1;
        end
      end
      RESP: begin
        if (owner ? resp1_ready : resp0_ready) begin
          resp0_valid_next = 1'b0;
          resp1_valid_next = 1'b0;
          state_next       = IDLE;
`ifndef CORDIC_ARB_FIXED_PRIO_EN
          rr_ptr_next      = ~owner;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Scoreboard bench for cordic_arbiter: LATENCY=16 instance with a delay-line core stub,
// plus a LATENCY=1 instance checking back-to-back grant order and spacing.
`timescale 1ns/1ps
module tb_cordic_arbiter;
  localparam int W   = 16;
  localparam int LAT = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- main DUT (LATENCY=16) ----------------
  logic reset;
  logic req0_valid, req0_ready, req0_mode, req1_valid, req1_ready, req1_mode;
  logic [W-1:0] req0_x, req0_y, req0_z, req1_x, req1_y, req1_z;
  logic resp0_valid, resp0_ready, resp1_valid, resp1_ready, cor_mode, busy;
  logic [W-1:0] resp_res1, resp_res2, cor_x, cor_y, cor_z, cor_res1, cor_res2;

  cordic_arbiter #(.WIDTH(W), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
    .req0_x(req0_x), .req0_y(req0_y), .req0_z(req0_z),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
    .req1_x(req1_x), .req1_y(req1_y), .req1_z(req1_z),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_res1(resp_res1), .resp_res2(resp_res2),
    .cor_mode(cor_mode), .cor_x(cor_x), .cor_y(cor_y), .cor_z(cor_z),
    .cor_res1(cor_res1), .cor_res2(cor_res2), .busy(busy));

  // Core stub: res1 = x, res2 = z, valid LAT edges after the operands change.
  logic [W-1:0] px [0:LAT-2];
  logic [W-1:0] pz [0:LAT-2];
  always @(posedge clk) begin
    px[0] <= cor_x;
    pz[0] <= cor_z;
    for (int i = 1; i < LAT - 1; i++) begin
      px[i] <= px[i-1];
      pz[i] <= pz[i-1];
    end
  end
  assign cor_res1 = px[LAT-2];
  assign cor_res2 = pz[LAT-2];

  typedef struct {
    logic         owner;
    logic         mode;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] z;
  } exp_t;
  exp_t sbq[$];
  int   acc_q[$];
  int   n_acc = 0, n_resp = 0, last_acc = 0;
  logic acc_pend = 1'b0, pv0 = 1'b0, pv1 = 1'b0;

  // Monitor: samples on the falling edge, checks grants, operands and responses.
  always @(negedge clk) begin
    if (reset) begin
      acc_pend = 1'b0; pv0 = 1'b0; pv1 = 1'b0;
    end else begin
      chk("ready_exclusive", {62'd0, req0_ready, req1_ready} == 64'd3, 64'd0);
      chk("ready_when_busy", {63'd0, busy & (req0_ready | req1_ready)}, 64'd0);
      if (acc_pend) begin
        acc_pend = 1'b0;
        if (sbq.size() != 0) begin
          chk("cor_x", cor_x, sbq[0].x);
          chk("cor_y", cor_y, sbq[0].y);
          chk("cor_z", cor_z, sbq[0].z);
          chk("cor_mode", cor_mode, sbq[0].mode);
        end
      end
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        if (sbq.size() == 0) begin
          chk("unexpected_accept", 64'd1, 64'd0);
        end else begin
          chk("grant_owner", req1_ready, sbq[0].owner);
        end
        acc_pend = 1'b1;
        last_acc = cyc + 1;
        acc_q.push_back(cyc + 1);
        n_acc++;
      end
      if ((resp0_valid && !pv0) || (resp1_valid && !pv1)) begin
        if (sbq.size() == 0) begin
          chk("unexpected_resp", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("resp_owner", {resp1_valid, resp0_valid}, e.owner ? 64'd2 : 64'd1);
          chk("resp_res1", resp_res1, e.x);
          chk("resp_res2", resp_res2, e.z);
          chk("resp_latency", cyc - last_acc, LAT);
        end
        n_resp++;
      end
      pv0 = resp0_valid;
      pv1 = resp1_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int target, input int budget);
    int k = 0;
    while (n_acc < target && k < budget) begin
      @(negedge clk); #1; k++;
    end
    if (n_acc < target) chk("accept_timeout", n_acc, target);
  endtask

  task automatic wait_resp(input int target, input int budget);
    int k = 0;
    while (n_resp < target && k < budget) begin
      @(negedge clk); #1; k++;
    end
    if (n_resp < target) chk("resp_timeout", n_resp, target);
  endtask

  task automatic push(input logic o, input logic m, input logic [W-1:0] x,
                      input logic [W-1:0] y, input logic [W-1:0] z);
    exp_t e;
    e.owner = o; e.mode = m; e.x = x; e.y = y; e.z = z;
    sbq.push_back(e);
  endtask

  task automatic check_reset_outputs(input string name);
    chk(name, {busy, resp0_valid, resp1_valid, req0_ready, req1_ready, cor_mode,
               cor_x, cor_y, cor_z}, 64'd0);
    chk({name, "_res"}, {resp_res1, resp_res2}, 64'd0);
  endtask

  // ---------------- LATENCY=1 DUT ----------------
  logic rst1;
  logic l0_ready, l1_ready, lr0_valid, lr1_valid, l_mode, l_busy;
  logic [W-1:0] l_res1, l_res2, l_cx, l_cy, l_cz;
  logic l_v = 1'b0;
  logic l1_done = 1'b0;

  cordic_arbiter #(.WIDTH(W), .LATENCY(1)) dut1 (
    .clk(clk), .reset(rst1),
    .req0_valid(l_v), .req0_ready(l0_ready), .req0_mode(1'b0),
    .req0_x(16'h0011), .req0_y(16'h0000), .req0_z(16'h0033),
    .req1_valid(l_v), .req1_ready(l1_ready), .req1_mode(1'b1),
    .req1_x(16'h0022), .req1_y(16'h0000), .req1_z(16'h0044),
    .resp0_valid(lr0_valid), .resp0_ready(1'b1),
    .resp1_valid(lr1_valid), .resp1_ready(1'b1),
    .resp_res1(l_res1), .resp_res2(l_res2),
    .cor_mode(l_mode), .cor_x(l_cx), .cor_y(l_cy), .cor_z(l_cz),
    .cor_res1(l_cx), .cor_res2(l_cz), .busy(l_busy));

  initial begin
    int acc_c[$], acc_o[$], rsp_c[$], rsp_x[$];
    logic q0 = 1'b0, q1 = 1'b0;
    logic exp_o;
    rst1 = 1'b1;
    tick(2);
    rst1 = 1'b0;
    l_v  = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (l0_ready || l1_ready) begin
        acc_c.push_back(cyc + 1);
        acc_o.push_back(int'(l1_ready));
      end
      if ((lr0_valid && !q0) || (lr1_valid && !q1)) begin
        rsp_c.push_back(cyc);
        rsp_x.push_back(int'(l_res1));
        chk("l1_res2", l_res2, lr1_valid ? 16'h0044 : 16'h0033);
      end
      q0 = lr0_valid;
      q1 = lr1_valid;
    end
    l_v = 1'b0;
    chk("l1_accept_count", acc_c.size() >= 4, 64'd1);
    chk("l1_resp_count", rsp_c.size() >= 4, 64'd1);
    for (int k = 0; k < 4 && k < acc_c.size() && k < rsp_c.size(); k++) begin
`ifdef CORDIC_ARB_FIXED_PRIO_EN
      exp_o = 1'b0;
`else
      exp_o = k[0];
`endif
      chk("l1_owner", acc_o[k], exp_o);
      chk("l1_resp_latency", rsp_c[k] - acc_c[k], 1);
      chk("l1_res1", rsp_x[k], exp_o ? 16'h0022 : 16'h0011);
      if (k > 0) chk("l1_spacing", acc_c[k] - acc_c[k-1], 3);
    end
    l1_done = 1'b1;
  end

  // ---------------- main stimulus ----------------
  initial begin
    int base, c;
    logic o2;
`ifdef CORDIC_ARB_FIXED_PRIO_EN
    o2 = 1'b0;
`else
    o2 = 1'b1;
`endif
    reset = 1'b1;
    {req0_valid, req0_mode, req0_x, req0_y, req0_z} = '0;
    {req1_valid, req1_mode, req1_x, req1_y, req1_z} = '0;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    tick(3);
    check_reset_outputs("reset_state");
    reset = 1'b0;
    tick(2);
    check_reset_outputs("post_reset_idle");

    // Single job on requester 0.
    push(1'b0, 1'b1, 16'h1A60, 16'h0E00, 16'h0200);
    req0_valid = 1'b1; req0_mode = 1'b1;
    req0_x = 16'h1A60; req0_y = 16'h0E00; req0_z = 16'h0200;
    wait_acc(1, 10);
    tick(1);
    req0_valid = 1'b0;
    chk("ready_one_cycle", req0_ready, 1'b0);
    wait_resp(1, 40);
    tick(3);

    // Round-robin from a fresh reset with both requesters held valid.
    reset = 1'b1; tick(2); reset = 1'b0; tick(1);
    base = n_acc;
    push(1'b0, 1'b0, 16'hB994, 16'h0100, 16'h0300);
    if (o2) push(1'b1, 1'b1, 16'h8A2D, 16'h0500, 16'h7FFF);
    else    push(1'b0, 1'b0, 16'hB994, 16'h0100, 16'h0300);
    push(1'b0, 1'b0, 16'hB994, 16'h0100, 16'h0300);
    req0_valid = 1'b1; req0_mode = 1'b0; req0_x = 16'hB994; req0_y = 16'h0100; req0_z = 16'h0300;
    req1_valid = 1'b1; req1_mode = 1'b1; req1_x = 16'h8A2D; req1_y = 16'h0500; req1_z = 16'h7FFF;
    wait_acc(base + 3, 100);
    tick(1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_resp(n_resp + 1, 40);
    if (acc_q.size() >= 3) begin
      chk("rr_spacing_a", acc_q[acc_q.size()-2] - acc_q[acc_q.size()-3], LAT + 2);
      chk("rr_spacing_b", acc_q[acc_q.size()-1] - acc_q[acc_q.size()-2], LAT + 2);
    end
    tick(3);

    // Response stall on requester 0 while requester 1 waits.
    base = n_acc;
    resp0_ready = 1'b0;
    push(1'b0, 1'b0, 16'h1234, 16'h0001, 16'h0ABC);
    req0_valid = 1'b1; req0_x = 16'h1234; req0_y = 16'h0001; req0_z = 16'h0ABC;
    wait_acc(base + 1, 10);
    tick(1);
    req0_valid = 1'b0;
    push(1'b1, 1'b1, 16'h0F0F, 16'h0002, 16'hF0F0);
    req1_valid = 1'b1; req1_mode = 1'b1; req1_x = 16'h0F0F; req1_y = 16'h0002; req1_z = 16'hF0F0;
    wait_resp(n_resp + 1, 40);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_valid", {resp0_valid, resp1_valid}, 2'b10);
      chk("stall_res", {resp_res1, resp_res2}, {16'h1234, 16'h0ABC});
      chk("stall_req1_ready", req1_ready, 1'b0);
    end
    @(posedge clk); #1;
    resp0_ready = 1'b1;
    c = cyc;
    wait_acc(base + 2, 10);
    chk("stall_release_accept", acc_q[acc_q.size()-1], c + 2);
    tick(1);
    req1_valid = 1'b0;
    wait_resp(n_resp + 1, 40);
    tick(3);

    // Reset in the middle of WAIT aborts the job.
    base = n_acc;
    push(1'b0, 1'b1, 16'h0400, 16'h0300, 16'h8248);
    req0_valid = 1'b1; req0_mode = 1'b1; req0_x = 16'h0400; req0_y = 16'h0300; req0_z = 16'h8248;
    wait_acc(base + 1, 10);
    tick(1);
    req0_valid = 1'b0;
    tick(4);
    #1 reset = 1'b1;
    #1 check_reset_outputs("async_reset");
    sbq.delete();
    tick(2);
    reset = 1'b0;
    c = n_resp;
    tick(25);
    chk("no_resp_after_abort", n_resp, c);
    push(1'b1, 1'b0, 16'h2222, 16'h3333, 16'h4444);
    req1_valid = 1'b1; req1_mode = 1'b0; req1_x = 16'h2222; req1_y = 16'h3333; req1_z = 16'h4444;
    wait_acc(n_acc + 1, 10);
    tick(1);
    req1_valid = 1'b0;
    wait_resp(c + 1, 40);
    tick(3);

    c = 0;
    while (!l1_done && c < 200) begin
      tick(1); c++;
    end
    chk("l1_done", l1_done, 1'b1);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cordic_arbiter.md
Name: cordic_arbiter

Overview:
- Shares one cordic core between two requesters, each with an independent valid/ready job interface. Each job is one 16-bit sign-magnitude operand triple (x, y, z) plus a mode bit.
- Grants jobs round-robin and drives the core's operand inputs, holding them stable for the core's fixed latency. It then captures res1/res2 and returns them to the owning requester.
- Sits directly in front of the cordic core; requesters are upstream sequencers or test harnesses.

Parameters:
WIDTH, 16, operand/result width (sign bit MSB, magnitude below, 8 fraction bits; arbiter treats data as opaque)
LATENCY, 16, clk cycles from operand launch to valid core results; legal range 1..255

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req0_valid  in  1  requester 0 has a job
req0_ready  out  1  requester 0 job accepted this cycle when valid&ready
req0_mode  in  1  cordic mode for requester 0
req0_x / req0_y / req0_z  in  WIDTH each  requester 0 operands
req1_valid, req1_ready, req1_mode, req1_x, req1_y, req1_z  same as requester 0, for requester 1
resp0_valid  out  1  result for requester 0 is available
resp0_ready  in  1  requester 0 consumes result
resp1_valid  out  1  result for requester 1 is available
resp1_ready  in  1  requester 1 consumes result
resp_res1  out  WIDTH  captured core res1 (shared by both response channels)
resp_res2  out  WIDTH  captured core res2 (shared)
cor_mode  out  1  to core mode
cor_x / cor_y / cor_z  out  WIDTH each  to core operands
cor_res1 / cor_res2  in  WIDTH each  from core results
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async): state=IDLE, rr_ptr=0, owner=0, count=0, cor_mode=0, cor_x/y/z=0, resp_res1/res2=0, resp0/1_valid=0, busy=0.
- Grant, combinational in IDLE only:
  - only one valid → that requester;
  - both valid → requester rr_ptr;
  - none → no grant.
- reqN_ready = (state==IDLE) & grant==N. Ready is never high outside IDLE and never high for both requesters.
- States:
  - IDLE: on a handshake at a rising edge, register the granted mode/x/y/z into cor_*, owner=N, count=LATENCY-1, go to WAIT.
  - WAIT: cor_* held constant. If count!=0, decrement. If count==0, capture resp_res1=cor_res1 and resp_res2=cor_res2, set resp<owner>_valid=1, go to RESP.
  - RESP: resp<owner>_valid held; resp_res* stable. On resp<owner>_ready=1: clear valid, rr_ptr = ~owner, go to IDLE. The other resp_ready is ignored.
- Timing:
  - Results are sampled exactly LATENCY edges after the accept edge.
  - respN_valid rises on edge LATENCY after accept.
  - Minimum job spacing is LATENCY+2 cycles with resp_ready tied high.
- cor_* keep their last values in RESP and IDLE; they change only at an accept edge.
- The response channel may stall indefinitely; requests wait (ready low) and no new job is issued.
- A requester may drop valid before ready with no effect. A request asserted while busy is accepted on the first IDLE cycle.
- Reset asserted mid-job aborts it: no response is produced, and outputs go to reset values immediately.
- LATENCY=1: WAIT lasts one cycle (count starts at 0).

Optional Feature:
CORDIC_ARB_FIXED_PRIO_EN: when defined, requester 0 always wins simultaneous requests and rr_ptr is not used/updated. When undefined, round-robin as above.

Test Plan:
- Single job:
  - Stimulus: LATENCY=16, core stub registers res1=x, res2=z after 16 cycles. req0: mode=1, x=16'h1A60 (26.375), y=16'h0E00 (14), z=16'h0200 (2).
  - Required: req0_ready high 1 cycle; cor_x=16'h1A60 the edge after; resp0_valid rises 16 edges after accept with resp_res1=16'h1A60, resp_res2=16'h0200; resp1_valid stays 0.
- Simultaneous requests, round-robin:
  - Stimulus: after reset, req0 x=16'hB994, req1 x=16'h8A2D, both valid, resp ready tied high.
  - Required: req0 served first, then req1; then req0 again while both remain valid; responses arrive on resp0 then resp1; spacing 18 cycles.
- Response stall:
  - Stimulus: resp0_ready=0 for 10 cycles while req1_valid=1.
  - Required: resp0_valid and resp_res* stable for all 10 cycles; req1_ready=0 throughout; req1 accepted on the cycle after resp0_ready=1 is sampled.
- Reset mid-WAIT:
  - Stimulus: assert reset 5 cycles after accepting z=16'h8248 (-2.28125).
  - Required: all outputs zero immediately (asynchronous); no resp valid after release; next job runs a normal 16-cycle latency.
- LATENCY=1 and fixed priority:
  - Stimulus: LATENCY=1, both requesters valid continuously, CORDIC_ARB_FIXED_PRIO_EN defined.
  - Required: only req0 is ever granted; resp0_valid rises 1 edge after each accept; jobs spaced 3 cycles apart.
